// File: rtl/imm_extend_sequencer.sv
// rtl/imm_extend_sequencer.sv - SPARC V8 immediate/target sequencer driving a shared sign-extender
module imm_extend_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_load,
    output logic        ir_ready,
    input  logic [31:0] IR,
    input  logic [31:0] PC,
    input  logic        flush,
    output logic [31:0] ir_q,
    output logic [1:0]  S,
    input  logic [31:0] se_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  kind,
    output logic [31:0] imm_out,
    output logic [31:0] target_out,
    output logic        has_target
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CALC,
        ST_DONE
    } state_t;

    localparam logic [2:0] KIND_NONE   = 3'd0;
    localparam logic [2:0] KIND_SIMM13 = 3'd1;
    localparam logic [2:0] KIND_DISP22 = 3'd2;
    localparam logic [2:0] KIND_DISP30 = 3'd3;
    localparam logic [2:0] KIND_SETHI  = 3'd4;

    // Counter preload: the extender output is sampled on the edge where it reaches zero.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [3:0]  cnt;
    logic [2:0]  dec_kind;
    logic [1:0]  dec_sel;
    logic        accept;

    assign accept = (state == ST_IDLE) && ir_load && !flush;

    // Format decode of the incoming instruction word into kind and extender select.
    always_comb begin
        dec_kind = KIND_NONE;
        dec_sel  = 2'b11;
        case (IR[31:30])
            2'b01: begin
                dec_kind = KIND_DISP30;
                dec_sel  = 2'b10;
            end
            2'b00: begin
                if (IR[24:22] == 3'b010 || IR[24:22] == 3'b110) begin
                    dec_kind = KIND_DISP22;
                    dec_sel  = 2'b01;
                end else if (IR[24:22] == 3'b100) begin
                    dec_kind = KIND_SETHI;
                    dec_sel  = 2'b11;
                end
            end
            default: begin
                if (IR[13]) begin
                    dec_kind = KIND_SIMM13;
                    dec_sel  = 2'b00;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; flush masks out_valid so an aborted result is never transferred.
    always_comb begin
        state_nxt = state;
        ir_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                ir_ready = 1'b1;
                if (accept) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                state_nxt = flush ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                out_valid = !flush;
                if (flush || out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, sample the extender after settling, then form the target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q       <= 32'd0;
            pc_q       <= 32'd0;
            S          <= 2'b00;
            kind       <= KIND_NONE;
            cnt        <= 4'd0;
            imm_out    <= 32'd0;
            target_out <= 32'd0;
            has_target <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ir_q <= IR;
                        pc_q <= PC;
                        kind <= dec_kind;
                        S    <= dec_sel;
                        cnt  <= CNT_INIT;
                    end
                end
                ST_SETTLE: begin
                    if (!flush) begin
                        if (cnt == 4'd0) begin
                            case (kind)
                                KIND_SIMM13, KIND_DISP22, KIND_DISP30: imm_out <= se_in;
                                KIND_SETHI: imm_out <= {se_in[21:0], 10'b0};
                                default:    imm_out <= 32'd0;
                            endcase
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                ST_CALC: begin
                    if (!flush) begin
                        if (kind == KIND_DISP22 || kind == KIND_DISP30) begin
                            target_out <= pc_q + (imm_out << 2);
                            has_target <= 1'b1;
                        end else begin
                            target_out <= 32'd0;
                            has_target <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_sequencer.sv
// tb/tb_imm_extend_sequencer.sv - self-checking bench for imm_extend_sequencer
module tb_imm_extend_sequencer;

    logic        clk;
    logic        rst        [2];
    logic        ir_load    [2];
    logic        ir_ready   [2];
    logic [31:0] ir_v       [2];
    logic [31:0] pc_v       [2];
    logic        flush      [2];
    logic [31:0] ir_q       [2];
    logic [1:0]  s_o        [2];
    logic [31:0] se_in      [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic [2:0]  kind       [2];
    logic [31:0] imm_out    [2];
    logic [31:0] target_out [2];
    logic        has_target [2];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL dut%0d %s actual=%h required=%h t=%0t", d, nm, act, exp, $time);
        end
    endtask

    // Extender behaviour: sign-extend the field picked by the select.
    function automatic logic [31:0] se_model(input logic [31:0] i, input logic [1:0] s);
        case (s)
            2'b00:   return {{19{i[12]}}, i[12:0]};
            2'b01:   return {{10{i[21]}}, i[21:0]};
            2'b10:   return {{2{i[29]}}, i[29:0]};
            default: return i;
        endcase
    endfunction

    function automatic void ref_decode(input logic [31:0] i, output logic [2:0] k, output logic [1:0] s);
        logic [1:0] op;
        logic [2:0] op2;
        op  = i[31:30];
        op2 = i[24:22];
        if (op == 2'b01) begin
            k = 3'd3; s = 2'b10;
        end else if (op == 2'b00 && (op2 == 3'b010 || op2 == 3'b110)) begin
            k = 3'd2; s = 2'b01;
        end else if (op == 2'b00 && op2 == 3'b100) begin
            k = 3'd4; s = 2'b11;
        end else if (op[1] && i[13]) begin
            k = 3'd1; s = 2'b00;
        end else begin
            k = 3'd0; s = 2'b11;
        end
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] k, input logic [1:0] s);
        if (k == 3'd1 || k == 3'd2 || k == 3'd3) return se_model(i, s);
        if (k == 3'd4) return {i[21:0], 10'b0};
        return 32'd0;
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0:       return {2'b01, r[29:0]};
            1:       return {2'b00, r[29:25], r[0] ? 3'b010 : 3'b110, r[21:0]};
            2:       return {2'b00, r[29:25], 3'b100, r[21:0]};
            3:       return {1'b1, r[30:14], 1'b1, r[12:0]};
            default: return r;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int SCG = (g == 0) ? 1 : 4;

        int          stab;
        logic [31:0] last_irq;
        logic [1:0]  last_s;
        logic        m_busy;
        int          m_age;
        logic [31:0] m_irq;
        logic [1:0]  m_s;
        logic [2:0]  m_kind;
        logic [31:0] m_imm;
        logic [31:0] m_tgt;
        logic        m_ht;
        logic        m_known;
        logic        exp_v;

        imm_extend_sequencer #(.SETTLE_CYCLES(SCG)) u_dut (
            .clk        (clk),
            .reset      (rst[g]),
            .ir_load    (ir_load[g]),
            .ir_ready   (ir_ready[g]),
            .IR         (ir_v[g]),
            .PC         (pc_v[g]),
            .flush      (flush[g]),
            .ir_q       (ir_q[g]),
            .S          (s_o[g]),
            .se_in      (se_in[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .kind       (kind[g]),
            .imm_out    (imm_out[g]),
            .target_out (target_out[g]),
            .has_target (has_target[g])
        );

        // Extender gives a corrupted value until its inputs have been stable for SCG cycles.
        assign se_in[g] = (stab >= SCG) ? se_model(ir_q[g], s_o[g])
                                        : (se_model(ir_q[g], s_o[g]) ^ 32'h5A5A_A5A5);

        always @(negedge clk) begin
            if (ir_q[g] !== last_irq || s_o[g] !== last_s) stab = 1;
            else if (stab < 100) stab++;
            last_irq = ir_q[g];
            last_s   = s_o[g];
        end

        // Reference model: a transaction is busy from accept until transfer/flush; valid after SCG+1 edges.
        always @(posedge clk or posedge rst[g]) begin
            if (rst[g]) begin
                m_busy = 1'b0; m_age = 0; m_irq = '0; m_s = '0; m_kind = '0;
                m_imm = '0; m_tgt = '0; m_ht = 1'b0; m_known = 1'b1;
            end else if (!m_busy) begin
                if (ir_load[g] && !flush[g]) begin
                    m_busy  = 1'b1;
                    m_age   = 0;
                    m_irq   = ir_v[g];
                    ref_decode(ir_v[g], m_kind, m_s);
                    m_imm   = ref_imm(ir_v[g], m_kind, m_s);
                    m_ht    = (m_kind == 3'd2 || m_kind == 3'd3);
                    m_tgt   = m_ht ? pc_v[g] + m_imm * 4 : 32'd0;
                    m_known = 1'b0;
                end
            end else if (flush[g]) begin
                m_busy = 1'b0;
            end else if (m_age >= SCG + 1) begin
                if (out_ready[g]) m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end

        always @(negedge clk) begin
            exp_v = m_busy && (m_age >= SCG + 1) && !flush[g];
            chk(g, "ir_ready", 32'(ir_ready[g]), 32'(!m_busy));
            chk(g, "out_valid", 32'(out_valid[g]), 32'(exp_v));
            chk(g, "ir_q", ir_q[g], m_irq);
            chk(g, "S", 32'(s_o[g]), 32'(m_s));
            if (exp_v || m_known) begin
                chk(g, "kind", 32'(kind[g]), 32'(m_kind));
                chk(g, "imm_out", imm_out[g], m_imm);
                chk(g, "target_out", target_out[g], m_tgt);
                chk(g, "has_target", 32'(has_target[g]), 32'(m_ht));
            end
        end
    end

    task automatic run_txn(input int d, input logic [31:0] i, input logic [31:0] p, output int lat);
        @(posedge clk); #1;
        ir_load[d] = 1'b1; ir_v[d] = i; pc_v[d] = p;
        @(posedge clk); lat = 1; #1;
        ir_load[d] = 1'b0;
        @(negedge clk);
        while (!out_valid[d] && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input int d, input logic [1:0] s, input logic [2:0] k,
                                input logic [31:0] imm, input logic [31:0] tgt, input logic ht);
        chk(d, "lit_S", 32'(s_o[d]), 32'(s));
        chk(d, "lit_kind", 32'(kind[d]), 32'(k));
        chk(d, "lit_imm", imm_out[d], imm);
        chk(d, "lit_target", target_out[d], tgt);
        chk(d, "lit_has_target", 32'(has_target[d]), 32'(ht));
    endtask

    initial begin
        int lat;
        int seen;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; ir_load[d] = 1'b0; flush[d] = 1'b0; out_ready[d] = 1'b1;
            ir_v[d] = '0; pc_v[d] = '0;
        end
        out_ready[1] = 1'b0;
        @(posedge clk); @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(d, "rst_ir_ready", 32'(ir_ready[d]), 32'd1);
            chk(d, "rst_out_valid", 32'(out_valid[d]), 32'd0);
            check_result(d, 2'b00, 3'd0, 32'd0, 32'd0, 1'b0);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        // CALL, Bicc, ALU immediate (i=1 and i=0), SETHI
        run_txn(0, 32'h7FFF_FFFF, 32'h0000_1000, lat);
        chk(0, "call_latency", 32'(lat), 32'd3);
        check_result(0, 2'b10, 3'd3, 32'hFFFF_FFFF, 32'h0000_0FFC, 1'b1);
        run_txn(0, 32'h0080_0004, 32'h0000_2000, lat);
        check_result(0, 2'b01, 3'd2, 32'h0000_0004, 32'h0000_2010, 1'b1);
        run_txn(0, 32'h8000_3FFF, 32'h0000_3000, lat);
        check_result(0, 2'b00, 3'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_txn(0, 32'h8000_0001, 32'h0000_3000, lat);
        check_result(0, 2'b11, 3'd0, 32'd0, 32'd0, 1'b0);
        run_txn(0, 32'h0100_0001, 32'h0000_4000, lat);
        check_result(0, 2'b11, 3'd4, 32'h0000_0400, 32'd0, 1'b0);
        @(posedge clk);

        // Backpressure with SETTLE_CYCLES=4
        run_txn(1, 32'h0080_0004, 32'h0000_2000, lat);
        chk(1, "bp_latency", 32'(lat), 32'd6);
        check_result(1, 2'b01, 3'd2, 32'h0000_0004, 32'h0000_2010, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            ir_load[1] = (k == 1); ir_v[1] = 32'h7FFF_FFFF;
            @(negedge clk);
            chk(1, "bp_valid_held", 32'(out_valid[1]), 32'd1);
            chk(1, "bp_ready_low", 32'(ir_ready[1]), 32'd0);
            chk(1, "bp_target_held", target_out[1], 32'h0000_2010);
        end
        @(posedge clk); #1;
        ir_load[1] = 1'b0; out_ready[1] = 1'b1;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        @(negedge clk);
        chk(1, "bp_idle_ready", 32'(ir_ready[1]), 32'd1);
        chk(1, "bp_idle_valid", 32'(out_valid[1]), 32'd0);
        chk(1, "bp_load_ignored", ir_q[1], 32'h0080_0004);

        // Flush during SETTLE
        @(posedge clk); #1;
        ir_load[1] = 1'b1; ir_v[1] = 32'h8000_3FFF;
        @(posedge clk); #1;
        ir_load[1] = 1'b0; flush[1] = 1'b1;
        @(posedge clk); #1;
        flush[1] = 1'b0;
        @(negedge clk);
        chk(1, "flush_ready", 32'(ir_ready[1]), 32'd1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid[1]) seen++;
        end
        chk(1, "flush_no_valid", 32'(seen), 32'd0);

        // Reset pulsed during CALC
        @(posedge clk); #1;
        ir_load[0] = 1'b1; ir_v[0] = 32'h0080_0004; pc_v[0] = 32'h0000_2000;
        @(posedge clk); #1;
        ir_load[0] = 1'b0;
        @(posedge clk); #2;
        rst[0] = 1'b1;
        #1;
        chk(0, "rstmid_ready", 32'(ir_ready[0]), 32'd1);
        chk(0, "rstmid_valid", 32'(out_valid[0]), 32'd0);
        chk(0, "rstmid_ir_q", ir_q[0], 32'd0);
        check_result(0, 2'b00, 3'd0, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        rst[0] = 1'b0;

        // Randomized traffic on both instances, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                rst[d]       = ($urandom_range(0, 399) == 0);
                ir_load[d]   = $urandom_range(0, 1) == 1;
                flush[d]     = ($urandom_range(0, 24) == 0);
                out_ready[d] = ($urandom_range(0, 2) != 0);
                ir_v[d]      = rand_ir();
                pc_v[d]      = $urandom;
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; ir_load[d] = 1'b0; flush[d] = 1'b0; out_ready[d] = 1'b1;
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
